// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// pipeline register indices, counter width and a saturating increment.
package pipe_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  localparam int CNT_W = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the ID/EX load and the
// instruction sitting in IF/ID. Register 0 never creates a dependency.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  mem_read_i,
  input  logic                  ex_valid_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  output logic                  hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rd_i == id_rs_i);
  assign rt_match = id_uses_rt_i & (ex_rd_i == id_rt_i);

  assign hazard_o = mem_read_i & ex_valid_i & id_valid_i &
                    (ex_rd_i != '0) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirect flushes
// and per-register valid tracking. Define HAZARD_PERF_CNT_EN for the
// saturating stall/flush performance counters.
module hazard_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_W     = 5,
  parameter int REDIRECT_STAGE = MEM_WB,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  redirect_req,
  output logic                  pc_en,
  output logic [NUM_STAGES-2:0] stage_en,
  output logic [NUM_STAGES-2:0] stage_flush,
  output logic [NUM_STAGES-2:0] stage_valid,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output state_e                dbg_state
);

  localparam int NR = NUM_STAGES - 1;

  state_e        state_q, state_d;
  logic [1:0]    scnt_q, scnt_d;
  logic [NR-1:0] valid_q, valid_d;
  logic          active;
  logic          hz;
  logic          rd;

  // Outputs are forced low while reset is held, not only after the edge.
  assign active = enable & arst_n;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .mem_read_i   (ex_mem_read),
    .ex_valid_i   (valid_q[ID_EX]),
    .id_valid_i   (valid_q[IF_ID]),
    .ex_rd_i      (ex_rd),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .hazard_o     (hz)
  );

  assign rd = redirect_req & valid_q[REDIRECT_STAGE];

  // Redirect beats both a fresh hazard and an ongoing multi-cycle stall.
  always_comb begin
    pc_en       = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    stall       = 1'b0;
    state_d     = state_q;
    scnt_d      = scnt_q;
    if (active) begin
      pc_en    = 1'b1;
      stage_en = '1;
      if (rd) begin
        for (int i = 0; i < REDIRECT_STAGE; i++) begin
          stage_flush[i] = 1'b1;
        end
        state_d = ST_RUN;
        scnt_d  = 2'd0;
      end else if (state_q == ST_STALL || hz) begin
        stall              = 1'b1;
        pc_en              = 1'b0;
        stage_en[IF_ID]    = 1'b0;
        stage_flush[ID_EX] = 1'b1;
        if (state_q == ST_STALL) begin
          if (scnt_q <= 2'd1) begin
            state_d = ST_RUN;
            scnt_d  = 2'd0;
          end else begin
            scnt_d = scnt_q - 2'd1;
          end
        end else if (LOAD_USE_STALL > 1) begin
          state_d = ST_STALL;
          scnt_d  = 2'(LOAD_USE_STALL - 1);
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (active) begin
      if (stage_flush[IF_ID]) begin
        valid_d[IF_ID] = 1'b0;
      end else if (stage_en[IF_ID]) begin
        valid_d[IF_ID] = 1'b1;
      end
      for (int i = 1; i < NR; i++) begin
        if (stage_flush[i]) begin
          valid_d[i] = 1'b0;
        end else if (stage_en[i]) begin
          valid_d[i] = valid_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_RUN;
      scnt_q  <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
    end
  end

  assign stage_valid = valid_q;
  assign dbg_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (enable) begin
      if (stall) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (rd) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: two instances (1-cycle and 3-cycle load-use
// stall) share stimulus and are checked every cycle against a reference model.
module tb_hazard_pipe_ctrl;
  import pipe_pkg::*;

  localparam int NS = 5;
  localparam int AW = 5;
  localparam int RS = 3;
  localparam int NR = NS - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // clock / reset / inputs
  logic          clk = 1'b0;
  logic          arst_n;
  logic          enable;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, redirect_req;

  logic          pc_en       [2];
  logic [NR-1:0] stage_en    [2];
  logic [NR-1:0] stage_flush [2];
  logic [NR-1:0] stage_valid [2];
  logic          stall       [2];
  logic [31:0]   stall_cnt   [2];
  logic [31:0]   flush_cnt   [2];
  state_e        dbg         [2];

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .REDIRECT_STAGE(RS), .LOAD_USE_STALL(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .redirect_req(redirect_req), .pc_en(pc_en[0]), .stage_en(stage_en[0]),
    .stage_flush(stage_flush[0]), .stage_valid(stage_valid[0]), .stall(stall[0]),
    .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]), .dbg_state(dbg[0])
  );

  hazard_pipe_ctrl #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .REDIRECT_STAGE(RS), .LOAD_USE_STALL(3)) u_dut3 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .redirect_req(redirect_req), .pc_en(pc_en[1]), .stage_en(stage_en[1]),
    .stage_flush(stage_flush[1]), .stage_valid(stage_valid[1]), .stall(stall[1]),
    .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]), .dbg_state(dbg[1])
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model: remaining stall cycles instead of an FSM
  int            lus      [2] = '{1, 3};
  bit [NR-1:0]   m_valid  [2];
  int            m_left   [2];
  longint        m_scnt   [2];
  longint        m_fcnt   [2];
  bit [NR-1:0]   nx_valid [2];
  int            nx_left  [2];
  longint        nx_scnt  [2];
  longint        nx_fcnt  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = '0; m_left[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
    end
  endtask

  task automatic model_check(input int d);
    bit act, hz, rd, e_pc, e_stall;
    bit [NR-1:0] e_en, e_fl, nv;
    int nleft;
    act = enable && arst_n;
    hz  = ex_mem_read && m_valid[d][1] && m_valid[d][0] && (ex_rd != 0) &&
          ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    rd  = redirect_req && m_valid[d][RS];
    e_pc = 0; e_stall = 0; e_en = '0; e_fl = '0; nleft = m_left[d];
    if (act) begin
      e_pc = 1; e_en = '1;
      if (rd) begin
        for (int i = 0; i < RS; i++) e_fl[i] = 1'b1;
        nleft = 0;
      end else if (m_left[d] > 0 || hz) begin
        e_stall = 1; e_pc = 0; e_en[0] = 1'b0; e_fl[1] = 1'b1;
        nleft = (m_left[d] > 0) ? m_left[d] - 1 : lus[d] - 1;
      end
    end
    check($sformatf("d%0d_pc_en", d), pc_en[d], e_pc);
    check($sformatf("d%0d_stall", d), stall[d], e_stall);
    check($sformatf("d%0d_stage_en", d), stage_en[d], e_en);
    check($sformatf("d%0d_stage_flush", d), stage_flush[d], e_fl);
    check($sformatf("d%0d_stage_valid", d), stage_valid[d], m_valid[d]);
    check($sformatf("d%0d_state", d), dbg[d], (m_left[d] > 0) ? ST_STALL : ST_RUN);
    check($sformatf("d%0d_stall_cnt", d), stall_cnt[d], CNT_ON ? m_scnt[d] : 0);
    check($sformatf("d%0d_flush_cnt", d), flush_cnt[d], CNT_ON ? m_fcnt[d] : 0);
    nv = m_valid[d];
    if (act) begin
      for (int i = 0; i < NR; i++) begin
        if (e_fl[i]) nv[i] = 1'b0;
        else if (e_en[i]) nv[i] = (i == 0) ? 1'b1 : m_valid[d][i-1];
      end
    end
    nx_valid[d] = nv;
    nx_left[d]  = nleft;
    nx_scnt[d]  = m_scnt[d] + longint'(e_stall);
    nx_fcnt[d]  = m_fcnt[d] + longint'(act && rd);
  endtask

  // driver tasks: inputs change at negedge, outputs sampled 1ns later
  task automatic settle();
    #1;
    if (!arst_n) model_reset();
    for (int d = 0; d < 2; d++) model_check(d);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nx_valid[d]; m_left[d] = nx_left[d];
      m_scnt[d]  = nx_scnt[d];  m_fcnt[d] = nx_fcnt[d];
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic quiet();
    enable = 1; ex_mem_read = 0; redirect_req = 0; ex_rd = 0;
    id_rs = 1; id_rt = 2; id_uses_rt = 0;
  endtask

  task automatic fill();
    quiet();
    repeat (6) cyc();
  endtask

  task automatic set_hazard(input logic [AW-1:0] r);
    ex_mem_read = 1; ex_rd = r; id_rs = r; id_rt = 9; id_uses_rt = 0;
  endtask

  int c0, c1;

  initial begin
    arst_n = 0; quiet(); enable = 0;
    model_reset();
    @(negedge clk);
    settle();
    check("reset_pc_en", pc_en[0], 0);
    advance();
    enable = 1;
    settle();
    check("reset_enabled_pc_en", pc_en[1], 0);
    check("reset_valid", stage_valid[1], 0);
    advance();

    // first cycle after release: RUN; redirect without valid[3] flushes nothing
    arst_n = 1; redirect_req = 1;
    settle();
    check("release_pc_en", pc_en[0], 1);
    check("redirect_invalid_no_flush", stage_flush[0], 0);
    advance();

    // single load-use hazard on r5
    fill();
    set_hazard(5);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      c0 += int'(stall[0]); c1 += int'(stall[1]);
      if (k == 0) begin
        check("lu_stall", stall[0], 1);
        check("lu_pc_en", pc_en[0], 0);
        check("lu_flush1", stage_flush[0][1], 1);
      end
      if (k == 1) check("lu_valid1_after", stage_valid[0][1], 0);
      advance();
      ex_mem_read = 0;
    end
    check("lu_stall_cycles_1", c0, 1);
    check("lu_stall_cycles_3", c1, 3);
    check("lu_stall_cnt_3", stall_cnt[1], CNT_ON ? 3 : 0);

    // redirect with a valid instruction in register 3
    fill();
    redirect_req = 1;
    settle();
    check("redirect_flush_d1", stage_flush[0], 4'b0111);
    check("redirect_flush_d3", stage_flush[1], 4'b0111);
    advance();
    redirect_req = 0;
    settle();
    check("redirect_flush_cnt", flush_cnt[0], CNT_ON ? 1 : 0);
    advance();

    // hazard and redirect together
    fill();
    set_hazard(6); redirect_req = 1;
    settle();
    check("hz_rd_stall_d1", stall[0], 0);
    check("hz_rd_stall_d3", stall[1], 0);
    check("hz_rd_flush_d3", stage_flush[1], 4'b0111);
    advance();
    quiet();
    settle();
    check("hz_rd_state_run", dbg[1], ST_RUN);
    advance();

    // redirect in the second cycle of a 3-cycle stall
    fill();
    set_hazard(4);
    cyc();
    quiet(); redirect_req = 1;
    settle();
    check("mid_stall_rd_stall", stall[1], 0);
    check("mid_stall_rd_pc_en", pc_en[1], 1);
    advance();
    redirect_req = 0;
    settle();
    check("mid_stall_rd_state", dbg[1], ST_RUN);
    check("mid_stall_rd_no_stall", stall[1], 0);
    advance();

    // load to r0 never stalls
    fill();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    settle();
    check("r0_no_stall_d1", stall[0], 0);
    check("r0_no_stall_d3", stall[1], 0);
    advance();

    // enable dropped mid-stall for 4 cycles
    fill();
    set_hazard(7);
    cyc();
    quiet(); enable = 0;
    repeat (4) cyc();
    enable = 1; c1 = 0;
    repeat (4) begin
      settle();
      c1 += int'(stall[1]);
      advance();
    end
    check("enable_resume_stalls", c1, 2);

    // reset pulsed during a stall
    fill();
    set_hazard(3);
    cyc();
    quiet(); arst_n = 0;
    settle();
    check("rst_mid_stall_pc_en", pc_en[1], 0);
    check("rst_mid_stall_valid", stage_valid[1], 0);
    check("rst_mid_stall_stall", stall[1], 0);
    advance();
    arst_n = 1;
    settle();
    check("rst_release_pc_en", pc_en[1], 1);
    check("rst_release_no_bubble", stall[1], 0);
    advance();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      arst_n       = ($urandom_range(0, 149) != 0);
      enable       = ($urandom_range(0, 9) != 0);
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_rd        = AW'($urandom_range(0, 3));
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      redirect_req = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
